// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display word in, multiplexed anode/segment drive out
interface seg7_scan_driver_if;
   logic [31:0] disp_data;
   logic [7:0]  disp_point;
   logic [7:0]  disp_en;
   logic [7:0]  disp_blink;
   logic [7:0]  an;
   logic [7:0]  seg;

   modport master (
      output disp_data, disp_point, disp_en, disp_blink,
      input  an, seg
   );

   modport slave (
      input  disp_data, disp_point, disp_en, disp_blink,
      output an, seg
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - eight-digit seven-segment scan driver with per-frame latching
module seg7_scan_driver #(
   parameter int SCAN_BIT  = 17,
   parameter int BLINK_BIT = 25
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        clk_div,
   seg7_scan_driver_if.slave  disp
);

   logic        prev_scan_q, prev_scan_d;
   logic [2:0]  idx_q, idx_d;
   logic        active_q, active_d;
   logic [31:0] shadow_data_q, shadow_data_d;
   logic [7:0]  shadow_point_q, shadow_point_d;
   logic [7:0]  shadow_en_q, shadow_en_d;
   logic [7:0]  shadow_blink_q, shadow_blink_d;

   logic        tick;
   logic        wrap;
   logic        dark;
   logic [3:0]  nib;
   logic        unused_clk_div;

   assign unused_clk_div = ^clk_div;
   assign tick = clk_div[SCAN_BIT] & ~prev_scan_q;
   assign wrap = tick & (idx_q == 3'd7);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      prev_scan_d    = clk_div[SCAN_BIT];
      idx_d          = idx_q;
      active_d       = active_q;
      shadow_data_d  = shadow_data_q;
      shadow_point_d = shadow_point_q;
      shadow_en_d    = shadow_en_q;
      shadow_blink_d = shadow_blink_q;
      if (tick) begin
         idx_d = idx_q + 3'd1;
      end
      // Shadows only reload at the frame boundary so a frame is never torn.
      if (wrap) begin
         active_d       = 1'b1;
         shadow_data_d  = disp.disp_data;
         shadow_point_d = disp.disp_point;
         shadow_en_d    = disp.disp_en;
         shadow_blink_d = disp.disp_blink;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_scan_q    <= 1'b0;
         idx_q          <= 3'd7;
         active_q       <= 1'b0;
         shadow_data_q  <= '0;
         shadow_point_q <= '0;
         shadow_en_q    <= '0;
         shadow_blink_q <= '0;
      end else begin
         prev_scan_q    <= prev_scan_d;
         idx_q          <= idx_d;
         active_q       <= active_d;
         shadow_data_q  <= shadow_data_d;
         shadow_point_q <= shadow_point_d;
         shadow_en_q    <= shadow_en_d;
         shadow_blink_q <= shadow_blink_d;
      end
   end

   assign nib  = shadow_data_q[{idx_q, 2'b00} +: 4];
   assign dark = ~active_q | ~shadow_en_q[idx_q] | (shadow_blink_q[idx_q] & clk_div[BLINK_BIT]);

   assign disp.an  = dark ? 8'hFF : ~(8'b1 << idx_q);
   assign disp.seg = dark ? 8'hFF : {~shadow_point_q[idx_q], hex7(nib)};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a frame-level model
module tb_seg7_scan_driver;
   localparam int SB = 2;
   localparam int BB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] clk_div;
   logic [31:0] cnt;
   int          n_vec = 0;
   int          n_err = 0;

   seg7_scan_driver_if bus();

   seg7_scan_driver #(.SCAN_BIT(SB), .BLINK_BIT(BB)) dut (
      .clk     (clk),
      .reset   (reset),
      .clk_div (clk_div),
      .disp    (bus.slave)
   );

   always #5 clk = ~clk;

   // Frame-level model: which digit is lit and what the frame snapshot holds.
   logic [6:0]  hex_tab  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [7:0]  scan_seg [8]  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
   bit          m_prev;
   int          m_digit;
   bit          m_active;
   bit          m_tick;
   logic [31:0] m_data;
   logic [7:0]  m_point, m_en, m_blink;

   function automatic logic [15:0] model_out();
      logic [7:0] an_e, seg_e;
      bit dark;
      dark = !m_active || !m_en[m_digit] || (m_blink[m_digit] && clk_div[BB]);
      an_e  = dark ? 8'hFF : (8'hFF ^ 8'(1 << m_digit));
      seg_e = dark ? 8'hFF : {~m_point[m_digit], hex_tab[(m_data >> (4 * m_digit)) & 32'hF]};
      return {an_e, seg_e};
   endfunction

   task automatic step();
      @(posedge clk);
      m_tick = 1'b0;
      if (reset) begin
         m_prev = 1'b0; m_digit = 7; m_active = 1'b0;
         m_data = '0; m_point = '0; m_en = '0; m_blink = '0;
      end else begin
         if (clk_div[SB] && !m_prev) begin
            m_tick = 1'b1;
            if (m_digit == 7) begin
               m_active = 1'b1;
               m_data = bus.disp_data; m_point = bus.disp_point;
               m_en = bus.disp_en; m_blink = bus.disp_blink;
            end
            m_digit = (m_digit + 1) % 8;
         end
         m_prev = clk_div[SB];
      end
      #1;
   endtask

   task automatic run_to_digit(input int d);
      for (int i = 0; i < 200; i++) begin
         clk_div = cnt; cnt = cnt + 1;
         step();
         if (m_tick && m_digit == d) return;
      end
      n_vec++; n_err++;
      $display("FAIL run_to_digit timeout: digit %0d not reached, required %0d", m_digit, d);
   endtask

   task automatic test_reset();
      bus.disp_data = 32'h76543210; bus.disp_point = 8'h00;
      bus.disp_en = 8'hFF; bus.disp_blink = 8'h00;
      reset = 1'b1; clk_div = 32'h0;
      step();
      n_vec++;
      if ({bus.an, bus.seg} !== 16'hFFFF) begin
         n_err++; $display("FAIL reset_out: an/seg=%h required FFFF", {bus.an, bus.seg});
      end
      reset = 1'b0;
      for (cnt = 0; cnt < 8; cnt++) begin
         clk_div = cnt;
         step();
         n_vec++;
         if (cnt < 4 && {bus.an, bus.seg} !== 16'hFFFF) begin
            n_err++; $display("FAIL pre_tick_dark cnt=%0d: an/seg=%h required FFFF", cnt, {bus.an, bus.seg});
         end else if (cnt >= 4 && {bus.an, bus.seg} !== 16'hFEC0) begin
            n_err++; $display("FAIL first_digit cnt=%0d: an/seg=%h required FEC0", cnt, {bus.an, bus.seg});
         end
      end
   endtask

   task automatic test_scan();
      for (int i = 0; i < 128; i++) begin
         clk_div = cnt; cnt = cnt + 1;
         step();
         n_vec++;
         if ({bus.an, bus.seg} !== model_out()) begin
            n_err++; $display("FAIL scan_model: an/seg=%h required %h", {bus.an, bus.seg}, model_out());
         end
         if (m_tick) begin
            n_vec++;
            if ({bus.an, bus.seg} !== {8'hFF ^ 8'(1 << m_digit), scan_seg[m_digit]}) begin
               n_err++; $display("FAIL scan_digit%0d: an/seg=%h required %h", m_digit,
                                 {bus.an, bus.seg}, {8'hFF ^ 8'(1 << m_digit), scan_seg[m_digit]});
            end
         end
      end
   endtask

   task automatic test_tearing();
      run_to_digit(3);
      bus.disp_data = 32'hFFFFFFFF;
      n_vec++;
      if (bus.seg !== 8'hB0) begin
         n_err++; $display("FAIL tear_digit3: seg=%h required B0", bus.seg);
      end
      for (int i = 0; i < 200; i++) begin
         clk_div = cnt; cnt = cnt + 1;
         step();
         if (m_tick && m_digit == 0) begin
            n_vec++;
            if (bus.seg !== 8'h8E) begin
               n_err++; $display("FAIL tear_wrap: seg=%h required 8E", bus.seg);
            end
            break;
         end else if (m_tick) begin
            n_vec++;
            if (bus.seg !== scan_seg[m_digit]) begin
               n_err++; $display("FAIL tear_old_digit%0d: seg=%h required %h", m_digit, bus.seg, scan_seg[m_digit]);
            end
         end
      end
   endtask

   task automatic test_point();
      bus.disp_data = 32'h00000008; bus.disp_point = 8'h01;
      run_to_digit(0);
      n_vec++;
      if ({bus.an, bus.seg} !== 16'hFE00) begin
         n_err++; $display("FAIL point_on: an/seg=%h required FE00", {bus.an, bus.seg});
      end
      bus.disp_point = 8'h00;
      run_to_digit(0);
      n_vec++;
      if ({bus.an, bus.seg} !== 16'hFE80) begin
         n_err++; $display("FAIL point_off: an/seg=%h required FE80", {bus.an, bus.seg});
      end
   endtask

   task automatic test_enable_blink();
      bus.disp_data = 32'h89ABCDEF; bus.disp_en = 8'hF0; bus.disp_blink = 8'h10;
      run_to_digit(0);
      for (int i = 0; i < 160; i++) begin
         clk_div = cnt; cnt = cnt + 1;
         step();
         n_vec++;
         if ({bus.an, bus.seg} !== model_out()) begin
            n_err++; $display("FAIL enblink_model: an/seg=%h required %h", {bus.an, bus.seg}, model_out());
         end
         n_vec++;
         if (m_digit < 4 && bus.an !== 8'hFF) begin
            n_err++; $display("FAIL disabled_digit%0d: an=%h required FF", m_digit, bus.an);
         end else if (m_digit == 4 && bus.an !== (clk_div[BB] ? 8'hFF : 8'hEF)) begin
            n_err++; $display("FAIL blink_digit4: an=%h required %h", bus.an, clk_div[BB] ? 8'hFF : 8'hEF);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.disp_data = 32'h76543210; bus.disp_en = 8'hFF; bus.disp_blink = 8'h00;
      run_to_digit(5);
      reset = 1'b1; clk_div = 32'h0;
      step();
      n_vec++;
      if ({bus.an, bus.seg} !== 16'hFFFF) begin
         n_err++; $display("FAIL reset_mid: an/seg=%h required FFFF", {bus.an, bus.seg});
      end
      clk_div = 32'h4;
      step();
      n_vec++;
      if ({bus.an, bus.seg} !== 16'hFFFF) begin
         n_err++; $display("FAIL reset_with_tick: an/seg=%h required FFFF", {bus.an, bus.seg});
      end
      reset = 1'b0; clk_div = 32'h5;
      step();
      n_vec++;
      if ({bus.an, bus.seg} !== 16'hFEC0) begin
         n_err++; $display("FAIL tick_after_reset: an/seg=%h required FEC0", {bus.an, bus.seg});
      end
      cnt = 32'h6;
   endtask

   task automatic test_wrap_hold();
      logic [15:0] held;
      run_to_digit(2);
      held = {bus.an, bus.seg};
      for (int i = 0; i < 26; i++) begin
         case (i)
            0:       clk_div = 32'hFFFFFFFC;
            1:       clk_div = 32'hFFFFFFFF;
            default: clk_div = 32'h0 + 32'(i % 4);
         endcase
         step();
         n_vec++;
         if ({bus.an, bus.seg} !== held) begin
            n_err++; $display("FAIL wrap_hold i=%0d: an/seg=%h required %h", i, {bus.an, bus.seg}, held);
         end
      end
      cnt = 32'h0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 96) == 0);
         if ($urandom_range(0, 7) == 0) clk_div = $urandom;
         else begin clk_div = cnt; cnt = cnt + 1; end
         if ($urandom_range(0, 15) == 0) begin
            bus.disp_data = $urandom; bus.disp_point = 8'($urandom);
            bus.disp_en = 8'($urandom); bus.disp_blink = 8'($urandom);
         end
         step();
         n_vec++;
         if ({bus.an, bus.seg} !== model_out()) begin
            n_err++; $display("FAIL random i=%0d: an/seg=%h required %h", i, {bus.an, bus.seg}, model_out());
         end
      end
   endtask

   initial begin
      reset = 1'b1; clk_div = '0; cnt = '0;
      test_reset();
      test_scan();
      test_tearing();
      test_point();
      test_enable_blink();
      test_reset_mid();
      test_wrap_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
